cla_seq_adder: RTL

Multi-cycle wide adder that reuses a single `cla_4bit` instance to add two WIDTH-bit operands one nibble per clock, rippling the carry through a register between nibbles. Sits directly upstream of the `cla_4bit` stage: it owns operand sequencing, carry chaining and result assembly, and feeds each nibble pair plus carry into the CLA. Trades latency (WIDTH/4 cycles) for area in datapaths that need wide adds occasionally.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_seq_adder_if.sv | 28 ++
 rtl/cla_4bit.sv | 19 +
 rtl/cla_seq_adder.sv | 74 +++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared nibble width, sequencer state encoding and index-width helper
package cla_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction
endpackage

// File: rtl/cla_seq_adder_if.sv
// cla_seq_adder_if: request/result bundle of the sequential adder (overflow only with CLA_SEQ_OVF_EN)
interface cla_seq_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_start;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
  logic             done;
`ifdef CLA_SEQ_OVF_EN
  logic             overflow;
`endif
  modport master (
    output start, a, b, carry_start,
`ifdef CLA_SEQ_OVF_EN
    input  overflow,
`endif
    input  sum, carry_out, busy, done
  );
  modport slave (
    input  start, a, b, carry_start,
`ifdef CLA_SEQ_OVF_EN
    output overflow,
`endif
    output sum, carry_out, busy, done
  );
endinterface

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder with fully expanded carry terms
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_start,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = carry_start;
  assign c[1] = g[0] | (p[0] & carry_start);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_start);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_start);
  assign carry_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry_start);
  assign sum = p ^ c;
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: nibble-serial wide adder around one cla_4bit; signed overflow output with CLA_SEQ_OVF_EN
module cla_seq_adder import cla_pkg::*; #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  cla_seq_adder_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);
  state_t               state;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic [IW-1:0]        idx;
  logic                 cy_q, cout_q, busy_q, done_q;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cy;
  logic                 last;
  assign last = idx == IW'(NIB - 1);
  cla_4bit u_cla (
    .a           (a_q[int'(idx) * NIBBLE_W +: NIBBLE_W]),
    .b           (b_q[int'(idx) * NIBBLE_W +: NIBBLE_W]),
    .carry_start (cy_q),
    .sum         (nib_sum),
    .carry_out   (nib_cy)
  );
`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;
  assign bus.overflow = ovf_q;
  // signed overflow judged from the latched operand signs and the final sum MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (state == RUN && last)
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
  // sequencer: latch on accept, then one nibble per edge with the carry rippling through cy_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_q    <= bus.a;
          b_q    <= bus.b;
          cy_q   <= bus.carry_start;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
      end else begin
        sum_q[int'(idx) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
        cy_q <= nib_cy;
        idx  <= idx + 1'b1;
        if (last) begin
          cout_q <= nib_cy;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
